// File: rtl/init_reset_sequencer.sv
// Power-up reset sequencer: synchronises POR and init-done flags, qualifies them
// for a stable window, then releases fabric reset domains one after another.
module init_reset_sequencer #(
    parameter int NUM_STATUS     = 4,
    parameter int NUM_DOMAINS    = 3,
    parameter int SYNC_STAGES    = 2,
    parameter int STABLE_CYCLES  = 16,
    parameter int STAGE_DELAY    = 8,
    parameter int TIMEOUT_CYCLES = 65535
) (
    input  logic                   clk,
    input  logic                   reset,
    input  logic                   por_n_in,
    input  logic [NUM_STATUS-1:0]  status_in,
    input  logic [NUM_STATUS-1:0]  status_mask,
    output logic [NUM_DOMAINS-1:0] rst_n_out,
    output logic                   init_done,
    output logic                   timeout_err,
    output logic [NUM_STATUS-1:0]  status_sync,
    output logic [2:0]             state
);
    // state   | meaning
    // IDLE    | waiting for POR and all required status flags
    // QUALIFY | flags good, counting consecutive good cycles
    // RELEASE | deasserting domain resets one by one, STAGE_DELAY apart
    // RUN     | all domains out of reset, init_done high
    // FAULT   | init never completed in time; left only through reset

    localparam int SW = $clog2(STABLE_CYCLES) + 1;
    localparam int DW = $clog2(STAGE_DELAY) + 1;
    localparam int TW = $clog2(TIMEOUT_CYCLES) + 1;
    localparam logic [SW-1:0] STAB_LAST = SW'(STABLE_CYCLES - 1);
    localparam logic [DW-1:0] DLY_LOAD  = DW'(STAGE_DELAY - 1);
    localparam logic [TW-1:0] TMO_LAST  = TW'(TIMEOUT_CYCLES - 1);
    localparam logic          STAB_ONE  = (STABLE_CYCLES == 1);

    typedef enum logic [2:0] {
        S_IDLE    = 3'd0,
        S_QUALIFY = 3'd1,
        S_RELEASE = 3'd2,
        S_RUN     = 3'd3,
        S_FAULT   = 3'd4
    } state_t;

    state_t                 state_q;
    logic [SYNC_STAGES-1:0] por_pipe;
    logic [NUM_STATUS-1:0]  status_pipe [SYNC_STAGES];
    logic [SW-1:0]          stab_cnt;
    logic [DW-1:0]          dly_cnt;
    logic [TW-1:0]          tmo_cnt;
    logic                   por_sync;
    logic                   all_ok;
    logic                   qual_done;

    assign por_sync    = por_pipe[SYNC_STAGES-1];
    assign status_sync = status_pipe[SYNC_STAGES-1];
    assign all_ok      = por_sync & (&(status_sync | ~status_mask));
    assign qual_done   = (state_q == S_QUALIFY) ? (stab_cnt == STAB_LAST) : STAB_ONE;
    assign state       = state_q;

    always_ff @(posedge clk) begin
        if (reset) begin
            por_pipe <= '0;
            for (int i = 0; i < SYNC_STAGES; i++) status_pipe[i] <= '0;
        end else begin
            por_pipe       <= {por_pipe[SYNC_STAGES-2:0], por_n_in};
            status_pipe[0] <= status_in;
            for (int i = 1; i < SYNC_STAGES; i++) status_pipe[i] <= status_pipe[i-1];
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state_q     <= S_IDLE;
            stab_cnt    <= '0;
            dly_cnt     <= '0;
            tmo_cnt     <= '0;
            rst_n_out   <= '0;
            init_done   <= 1'b0;
            timeout_err <= 1'b0;
        end else begin
            case (state_q)
                S_IDLE, S_QUALIFY: begin
                    tmo_cnt <= tmo_cnt + 1'b1;
                    // a completed qualification beats a timeout on the same edge
                    if (all_ok && qual_done) begin
                        state_q  <= S_RELEASE;
                        stab_cnt <= '0;
                        dly_cnt  <= '0;
                        tmo_cnt  <= '0;
                    end else if (tmo_cnt == TMO_LAST) begin
                        state_q     <= S_FAULT;
                        timeout_err <= 1'b1;
                    end else if (!all_ok) begin
                        state_q  <= S_IDLE;
                        stab_cnt <= '0;
                    end else begin
                        state_q  <= S_QUALIFY;
                        stab_cnt <= stab_cnt + 1'b1;
                    end
                end
                S_RELEASE: begin
                    if (!all_ok) begin
                        state_q   <= S_IDLE;
                        rst_n_out <= '0;
                        init_done <= 1'b0;
                        stab_cnt  <= '0;
                        dly_cnt   <= '0;
                        tmo_cnt   <= '0;
                    end else if (rst_n_out[NUM_DOMAINS-1]) begin
                        state_q   <= S_RUN;
                        init_done <= 1'b1;
                    end else if (dly_cnt == '0) begin
                        // shifting in ones keeps lower domains released
                        rst_n_out <= (rst_n_out << 1) | NUM_DOMAINS'(1);
                        dly_cnt   <= DLY_LOAD;
                    end else begin
                        dly_cnt <= dly_cnt - 1'b1;
                    end
                end
                S_RUN: begin
                    if (!all_ok) begin
                        state_q   <= S_IDLE;
                        rst_n_out <= '0;
                        init_done <= 1'b0;
                        stab_cnt  <= '0;
                        dly_cnt   <= '0;
                        tmo_cnt   <= '0;
                    end
                end
                S_FAULT: begin
                    rst_n_out   <= '0;
                    init_done   <= 1'b0;
                    timeout_err <= 1'b1;
                end
                default: begin
                    state_q   <= S_IDLE;
                    rst_n_out <= '0;
                    init_done <= 1'b0;
                end
            endcase
        end
    end
endmodule

// File: tb/tb_init_reset_sequencer.sv
// Scoreboard bench for init_reset_sequencer: a cycle-level behavioural model
// predicts every output after each edge, a monitor compares against the DUT.
module tb_init_reset_sequencer;
    localparam int NS   = 4;
    localparam int ND   = 3;
    localparam int SS   = 2;
    localparam int STAB = 16;
    localparam int DLY  = 8;
    localparam int TMO  = 100;

    logic          clk = 1'b0;
    logic          reset = 1'b1;
    logic          por_n_in = 1'b0;
    logic [NS-1:0] status_in = '0;
    logic [NS-1:0] status_mask = '1;
    logic [ND-1:0] rst_n_out;
    logic          init_done;
    logic          timeout_err;
    logic [NS-1:0] status_sync;
    logic [2:0]    state;

    init_reset_sequencer #(
        .NUM_STATUS(NS), .NUM_DOMAINS(ND), .SYNC_STAGES(SS),
        .STABLE_CYCLES(STAB), .STAGE_DELAY(DLY), .TIMEOUT_CYCLES(TMO)
    ) dut (
        .clk(clk), .reset(reset), .por_n_in(por_n_in), .status_in(status_in),
        .status_mask(status_mask), .rst_n_out(rst_n_out), .init_done(init_done),
        .timeout_err(timeout_err), .status_sync(status_sync), .state(state)
    );

    always #5 clk = ~clk;

    typedef struct {
        logic [ND-1:0] rst_n;
        logic          done;
        logic          terr;
        logic [2:0]    st;
        logic [NS-1:0] ss;
    } exp_t;

    exp_t exp_q[$];
    int   n_vec = 0;
    int   n_err = 0;

    // model: mode 0 = waiting for init, 1 = released (sequencing or running), 2 = faulted
    int            m_mode = 0;
    int            streak = 0;
    int            waited = 0;
    int            rel_age = 0;
    logic          por_p [SS];
    logic [NS-1:0] st_p [SS];

    task automatic step(input logic r, input logic p, input logic [NS-1:0] s, input logic [NS-1:0] m);
        exp_t e;
        logic ok;
        @(negedge clk);
        reset = r; por_n_in = p; status_in = s; status_mask = m;
        if (r) begin
            m_mode = 0; streak = 0; waited = 0; rel_age = 0;
            for (int i = 0; i < SS; i++) begin por_p[i] = 1'b0; st_p[i] = '0; end
        end else begin
            ok = por_p[SS-1] && ((st_p[SS-1] | ~m) == '1);
            for (int i = SS-1; i > 0; i--) begin por_p[i] = por_p[i-1]; st_p[i] = st_p[i-1]; end
            por_p[0] = p; st_p[0] = s;
            if (m_mode == 0) begin
                waited++;
                streak = ok ? streak + 1 : 0;
                if (streak == STAB) begin m_mode = 1; rel_age = 0; streak = 0; waited = 0; end
                else if (waited == TMO) m_mode = 2;
            end else if (m_mode == 1) begin
                if (!ok) begin m_mode = 0; streak = 0; waited = 0; rel_age = 0; end
                else if (rel_age < 10000) rel_age++;
            end
        end
        e.rst_n = '0; e.done = 1'b0; e.terr = 1'b0; e.ss = st_p[SS-1]; e.st = 3'd0;
        if (m_mode == 0) e.st = (streak > 0) ? 3'd1 : 3'd0;
        else if (m_mode == 1) begin
            for (int k = 0; k < ND; k++) e.rst_n[k] = (rel_age >= 1 + k*DLY);
            e.done = (rel_age >= 2 + (ND-1)*DLY);
            e.st = e.done ? 3'd3 : 3'd2;
        end else begin
            e.terr = 1'b1; e.st = 3'd4;
        end
        exp_q.push_back(e);
    endtask

    task automatic hold(input int n, input logic p, input logic [NS-1:0] s, input logic [NS-1:0] m);
        for (int i = 0; i < n; i++) step(1'b0, p, s, m);
    endtask

    task automatic do_reset(input int n);
        for (int i = 0; i < n; i++) step(1'b1, 1'b0, '0, status_mask);
    endtask

    always @(posedge clk) begin
        exp_t e;
        #1;
        if (exp_q.size() > 0) begin
            e = exp_q.pop_front();
            n_vec++;
            if (rst_n_out !== e.rst_n || init_done !== e.done || timeout_err !== e.terr ||
                state !== e.st || status_sync !== e.ss) begin
                n_err++;
                $display("FAIL vec%0d t=%0t: rst_n_out %b want %b, init_done %b want %b, timeout_err %b want %b, state %0d want %0d, status_sync %h want %h",
                         n_vec, $time, rst_n_out, e.rst_n, init_done, e.done, timeout_err, e.terr,
                         state, e.st, status_sync, e.ss);
            end
        end
    end

    initial begin
        #5_000_000;
        $display("FAIL watchdog: simulation time limit reached, %0d vectors pending", exp_q.size());
        $fatal(1, "watchdog");
    end

    initial begin
        logic [NS-1:0] m, s;
        logic p;
        // nominal bring-up
        do_reset(3);
        hold(45, 1'b1, 4'hF, 4'hF);
        // one-cycle dropout of bit 2 mid-qualification
        do_reset(2);
        hold(12, 1'b1, 4'hF, 4'hF);
        hold(1, 1'b1, 4'hB, 4'hF);
        hold(45, 1'b1, 4'hF, 4'hF);
        // masked-off flag never set
        do_reset(2);
        hold(45, 1'b1, 4'hB, 4'hB);
        // timeout, then late status must not recover
        do_reset(2);
        hold(110, 1'b1, 4'h0, 4'hF);
        hold(40, 1'b1, 4'hF, 4'hF);
        do_reset(1);
        // POR loss in RUN and replay
        hold(45, 1'b1, 4'hF, 4'hF);
        hold(3, 1'b0, 4'hF, 4'hF);
        hold(45, 1'b1, 4'hF, 4'hF);
        // reset mid-release
        do_reset(2);
        hold(20, 1'b1, 4'hF, 4'hF);
        do_reset(1);
        hold(45, 1'b1, 4'hF, 4'hF);
        // status loss mid-release, and mask change while running
        hold(3, 1'b1, 4'h7, 4'hF);
        hold(30, 1'b1, 4'hF, 4'hF);
        hold(20, 1'b1, 4'h7, 4'h7);
        // randomized episodes
        for (int ep = 0; ep < 80; ep++) begin
            if ($urandom_range(0, 3) == 0) do_reset($urandom_range(1, 2));
            m = NS'($urandom);
            for (int seg = 0; seg < 4; seg++) begin
                p = ($urandom_range(0, 7) != 0);
                s = ($urandom_range(0, 3) != 0) ? (m | NS'($urandom)) : NS'($urandom);
                if ($urandom_range(0, 5) == 0) m = NS'($urandom);
                hold($urandom_range(1, 40), p, s, m);
            end
        end
        do_reset(1);
        @(negedge clk);
        @(negedge clk);
        if (exp_q.size() != 0) begin
            n_err++;
            $display("FAIL drain: %0d expected vectors left unchecked, want 0", exp_q.size());
        end
        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end
endmodule

// File: doc/init_reset_sequencer.md
Name: init_reset_sequencer

Overview:
Parametrised successor to the PolarFire init-monitor wrapper. Consumes N asynchronous init-done/status flags (FABRIC_POR_N, DEVICE/SRAM/USRAM/XCVR init-done, bank calib status, etc.) and synchronises them. It then qualifies them for a programmable stable window and releases M active-low fabric reset domains in a staggered sequence. It flags a sticky timeout fault if init never completes, and re-arms on loss of status.

Parameters:
NUM_STATUS, 4, number of status inputs (1..16)
NUM_DOMAINS, 3, number of sequenced reset outputs (1..8)
SYNC_STAGES, 2, synchroniser flop depth per input (>=2)
STABLE_CYCLES, 16, consecutive cycles all required status must be good (>=1)
STAGE_DELAY, 8, cycles between successive domain releases (>=1)
TIMEOUT_CYCLES, 65535, cycles allowed in IDLE/QUALIFY before FAULT (>=2)

Ports:
clk  in  1  system clock
reset  in  1  synchronous, active-high reset
por_n_in  in  1  async fabric POR_N (always required)
status_in  in  NUM_STATUS  async init-done/status flags, active-high
status_mask  in  NUM_STATUS  1 = input required, 0 = ignored (quasi-static)
rst_n_out  out  NUM_DOMAINS  per-domain active-low reset, bit 0 released first
init_done  out  1  all domains released
timeout_err  out  1  sticky timeout fault
status_sync  out  NUM_STATUS  synchronised status_in (debug)
state  out  3  FSM state: IDLE=0, QUALIFY=1, RELEASE=2, RUN=3, FAULT=4

Behaviour:
- Reset is synchronous, active-high. While reset=1 at an edge: rst_n_out=0, init_done=0, timeout_err=0, state=IDLE, status_sync=0, all synchroniser flops=0, all counters=0.
- Synchronisers: SYNC_STAGES flops each on por_n_in and status_in. Output visible after SYNC_STAGES edges.
- all_ok (combinational) = por_sync AND &(status_sync | ~status_mask). If status_mask=0, all_ok = por_sync.
- IDLE: if all_ok -> QUALIFY, stab_cnt=1 (STABLE_CYCLES=1: go directly to RELEASE).
- QUALIFY:
  - if !all_ok -> IDLE, stab_cnt=0.
  - else if stab_cnt==STABLE_CYCLES-1 -> RELEASE, idx=0, dly=0.
  - else stab_cnt++.
  - Net effect: all_ok must be seen on STABLE_CYCLES consecutive edges.
- Timeout: tmo_cnt increments every edge in IDLE or QUALIFY. At an edge where tmo_cnt==TIMEOUT_CYCLES-1 -> FAULT, timeout_err=1. If the RELEASE transition happens on the same edge, RELEASE wins and no fault is raised. tmo_cnt clears on entering RELEASE and on any return to IDLE from RELEASE/RUN. It is not cleared by a QUALIFY->IDLE bounce.
- RELEASE: with T = the edge entering RELEASE:
  - rst_n_out[k] goes 1 at edge T+1+k*STAGE_DELAY.
  - The edge after rst_n_out[NUM_DOMAINS-1] rises -> RUN, init_done=1.
  - Released bits stay 1.
- RUN: holds all outputs. Terminal unless all_ok drops.
- Status loss in RELEASE or RUN: at the first edge where !all_ok:
  - all rst_n_out=0 and init_done=0 simultaneously, state=IDLE.
  - stab_cnt, idx, dly and tmo_cnt clear.
  - The sequence re-runs from scratch.
- FAULT: rst_n_out=0, init_done=0, timeout_err=1. Exit only via reset, regardless of all_ok.
- Changing status_mask mid-sequence: takes effect through all_ok on the same cycle; no other side effects.
- Counter widths: $clog2 of respective limit +1; counters never wrap (the terminal compare always fires first).
- reset asserted in any state returns to reset values on that edge.

Test Plan:
- Defaults, mask=4'hF, TIMEOUT_CYCLES=1000. por_n_in and status_in=4'hF set before edge E0 after reset release -> QUALIFY at E2; RELEASE at E17; rst_n_out[0]/[1]/[2] rise at E18/E26/E34; init_done=1 and state=3 at E35.
- Same setup, status_in[2] pulses low for 1 cycle during QUALIFY at stab_cnt=10 -> returns to IDLE, qualification restarts. rst_n_out[0] rises 16+ edges after status is good again.
- status_mask=4'b1011, status_in=4'b1011 (bit 2 never set) -> sequence completes normally. init_done=1 at the same edge offsets as the first scenario.
- TIMEOUT_CYCLES=100, status_in=0 -> state=4 and timeout_err=1 after the 100th edge following reset deassertion. rst_n_out stays 0. Raising status afterwards has no effect; reset clears timeout_err.
- In RUN, por_n_in drops -> 2 edges later (sync) plus 1: all rst_n_out=0 and init_done=0 on the same edge, state=0. Restoring por_n_in repeats the full sequence with identical spacing.
- reset asserted mid-RELEASE (after rst_n_out[0]=1) -> next edge: all outputs 0, state=IDLE. After reset release, the sequence replays from QUALIFY.
